// File: rtl/hp_burst_splitter.sv
// hp_burst_splitter
// Burst command planner for the HP memory port. Takes contiguous-run
// descriptors (start byte address, element count) and splits each run into
// bus burst commands that respect BUS_BYTES alignment, a MAX_BEATS cap and
// BOUNDARY-byte pages.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   desc_valid/ready     descriptor handshake; desc_addr (64b), desc_elems (32b)
//   cmd_valid/ready      command handshake; cmd_addr (64b), cmd_bytes (32b),
//                        cmd_len (beats-1), cmd_last (final burst of run)
//   busy                 a descriptor is being split
//   stat_*_cnt           wrapping 32-bit statistics, cleared only by reset
module hp_burst_splitter #(
  parameter int unsigned DATA_BYTES = 2,
  parameter int unsigned BUS_BYTES  = 32,
  parameter int unsigned MAX_BEATS  = 64,
  parameter int unsigned BOUNDARY   = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [63:0] desc_addr,
  input  logic [31:0] desc_elems,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [63:0] cmd_addr,
  output logic [31:0] cmd_bytes,
  output logic [7:0]  cmd_len,
  output logic        cmd_last,
  output logic        busy,
  output logic [31:0] stat_desc_cnt,
  output logic [31:0] stat_burst_cnt,
  output logic [31:0] stat_unaligned_cnt,
  output logic [31:0] stat_zero_cnt
);

  localparam int unsigned LOG_BUS  = $clog2(BUS_BYTES);
  localparam logic [39:0] BUS_W    = 40'(BUS_BYTES);
  localparam logic [39:0] BND_W    = 40'(BOUNDARY);
  localparam logic [39:0] CAP_W    = 40'(MAX_BEATS * BUS_BYTES);
  localparam logic [63:0] BUS_MASK = 64'(BUS_BYTES - 1);
  localparam logic [63:0] BND_MASK = 64'(BOUNDARY - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] cur_addr;
  logic [39:0] remain;   // 32-bit elems * DATA_BYTES never truncates in 40 bits
  logic [39:0] off_bus;
  logic [39:0] off_bnd;
  logic [39:0] to_bnd;
  logic [39:0] lim;
  logic [39:0] chunk;
  logic [39:0] beats;
  logic        is_last;
  logic        desc_hs;
  logic        cmd_hs;

  assign desc_hs = desc_valid & (state == IDLE);
  assign cmd_hs  = cmd_ready & (state == SPLIT);

  // Size of the next burst from the registered address and remaining bytes.
  always_comb begin
    off_bus = 40'(cur_addr & BUS_MASK);
    off_bnd = 40'(cur_addr & BND_MASK);
    to_bnd  = BND_W - off_bnd;
    if (off_bus != 40'd0) begin
      // Unaligned head: only reach the next beat boundary, so always one beat.
      lim = BUS_W - off_bus;
    end else if (to_bnd < CAP_W) begin
      lim = to_bnd;
    end else begin
      lim = CAP_W;
    end
    if (remain < lim) begin
      chunk = remain;
    end else begin
      chunk = lim;
    end
    beats   = (chunk + BUS_W - 40'd1) >> LOG_BUS;
    is_last = (chunk == remain);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs; command fields are forced to zero outside SPLIT.
  always_comb begin
    state_next = state;
    desc_ready = 1'b0;
    busy       = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = 64'd0;
    cmd_bytes  = 32'd0;
    cmd_len    = 8'd0;
    cmd_last   = 1'b0;
    case (state)
      IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid && (desc_elems != 32'd0)) begin
          state_next = SPLIT;
        end else begin
          state_next = IDLE;
        end
      end
      SPLIT: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = cur_addr;
        cmd_bytes = 32'(chunk);
        cmd_len   = 8'(beats - 40'd1);
        cmd_last  = is_last;
        if (cmd_ready && is_last) begin
          state_next = IDLE;
        end else begin
          state_next = SPLIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Run position: load on a non-empty descriptor, advance on each command.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur_addr <= 64'd0;
      remain   <= 40'd0;
    end else if (desc_hs && (desc_elems != 32'd0)) begin
      cur_addr <= desc_addr;
      remain   <= 40'(desc_elems) * 40'(DATA_BYTES);
    end else if (cmd_hs) begin
      cur_addr <= cur_addr + 64'(chunk);
      remain   <= remain - chunk;
    end else begin
      cur_addr <= cur_addr;
      remain   <= remain;
    end
  end

  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_desc_cnt      <= 32'd0;
      stat_burst_cnt     <= 32'd0;
      stat_unaligned_cnt <= 32'd0;
      stat_zero_cnt      <= 32'd0;
    end else begin
      if (desc_hs) begin
        stat_desc_cnt <= stat_desc_cnt + 32'd1;
        if (desc_elems == 32'd0) begin
          stat_zero_cnt <= stat_zero_cnt + 32'd1;
        end else if ((desc_addr & BUS_MASK) != 64'd0) begin
          stat_unaligned_cnt <= stat_unaligned_cnt + 32'd1;
        end else begin
          stat_unaligned_cnt <= stat_unaligned_cnt;
        end
      end else begin
        stat_desc_cnt <= stat_desc_cnt;
      end
      if (cmd_hs) begin
        stat_burst_cnt <= stat_burst_cnt + 32'd1;
      end else begin
        stat_burst_cnt <= stat_burst_cnt;
      end
    end
  end

endmodule
